// File: rtl/comparator_operand_gen.sv
// rtl/comparator_operand_gen.sv - operand front end for the 2-bit comparator demo
module comparator_operand_gen #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int DWELL_CYCLES    = 50000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sw_a1,
   input  logic       sw_a0,
   input  logic       sw_b1,
   input  logic       sw_b0,
   input  logic       btn_mode,
   input  logic       btn_step,
   output logic       a1,
   output logic       a0,
   output logic       b1,
   output logic       b0,
   output logic       opnd_valid,
   output logic [1:0] mode
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
   localparam int DW_W = $clog2(DWELL_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYCLES - 1);

   typedef enum logic [1:0] {
      MODE_MANUAL = 2'b00,
      MODE_AUTO   = 2'b01,
      MODE_STEP   = 2'b10,
      MODE_BAD    = 2'b11
   } mode_t;

   // bit order: {step, mode, a1, a0, b1, b0}
   logic [5:0]      raw;
   logic [5:0]      sync1;
   logic [5:0]      sync2;
   logic [5:0]      stable;
   logic [DB_W-1:0] db_cnt [6];
   logic [1:0]      btn_prev;
   logic            mode_press;
   logic            step_press;

   mode_t           state;
   mode_t           state_nxt;
   logic [DW_W-1:0] dwell_cnt;
   logic            dwell_done;

   logic [3:0]      op;
   logic [3:0]      op_nxt;
   logic            op_chg;

   assign raw = {btn_step, btn_mode, sw_a1, sw_a0, sw_b1, sw_b0};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable <= '0;
         for (int i = 0; i < 6; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 6; i++) begin
            if (sync2[i] == stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               stable[i] <= ~stable[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) btn_prev <= '0;
      else        btn_prev <= stable[5:4];
   end

   assign mode_press = stable[4] & ~btn_prev[0];
   assign step_press = stable[5] & ~btn_prev[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= MODE_MANUAL;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         MODE_MANUAL: if (mode_press) state_nxt = MODE_AUTO;
         MODE_AUTO:   if (mode_press) state_nxt = MODE_STEP;
         MODE_STEP:   if (mode_press) state_nxt = MODE_MANUAL;
         default:     state_nxt = MODE_MANUAL;
      endcase
   end

   always_comb begin
      mode = state;
   end

   assign dwell_done = (state == MODE_AUTO) && (dwell_cnt == DW_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                    dwell_cnt <= '0;
      else if (mode_press || state != MODE_AUTO || dwell_done) dwell_cnt <= '0;
      else                                           dwell_cnt <= dwell_cnt + DW_W'(1);
   end

   // A mode press wins over any same-cycle step or dwell increment.
   always_comb begin
      op_nxt = op;
      if (!mode_press) begin
         case (state)
            MODE_MANUAL: op_nxt = stable[3:0];
            MODE_AUTO:   if (dwell_done) op_nxt = op + 4'd1;
            MODE_STEP:   if (step_press) op_nxt = op + 4'd1;
            default:     op_nxt = op;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op         <= '0;
         op_chg     <= 1'b0;
         opnd_valid <= 1'b0;
      end else begin
         op         <= op_nxt;
         op_chg     <= (op_nxt != op);
         opnd_valid <= op_chg;
      end
   end

   assign {a1, a0, b1, b0} = op;

endmodule

// File: tb/tb_comparator_operand_gen.sv
// tb/tb_comparator_operand_gen.sv - self-checking bench for comparator_operand_gen
module tb_comparator_operand_gen;

   localparam int DB = 4;
   localparam int DW = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sw_a1 = 1'b0, sw_a0 = 1'b0, sw_b1 = 1'b0, sw_b0 = 1'b0;
   logic       btn_mode = 1'b0, btn_step = 1'b0;
   logic       a1, a0, b1, b0, opnd_valid;
   logic [1:0] mode;
   logic [3:0] op_now;

   int n_checks = 0;
   int n_fail = 0;
   logic [3:0] exp_q [$];

   typedef struct packed {
      logic [3:0] sw;
      logic [3:0] exp_op;
      logic       exp_valid;
   } vec_t;
   vec_t vecs [6];

   comparator_operand_gen #(.DEBOUNCE_CYCLES(DB), .DWELL_CYCLES(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .sw_a1(sw_a1), .sw_a0(sw_a0), .sw_b1(sw_b1), .sw_b0(sw_b0),
      .btn_mode(btn_mode), .btn_step(btn_step),
      .a1(a1), .a0(a0), .b1(b1), .b0(b0),
      .opnd_valid(opnd_valid), .mode(mode)
   );

   assign op_now = {a1, a0, b1, b0};

   always #5 clk = ~clk;

   task check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task tick(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task set_sw(input logic [3:0] v);
      {sw_a1, sw_a0, sw_b1, sw_b0} = v;
   endtask

   task automatic wait_mode(input logic [1:0] m, input int limit);
      int i = 0;
      while (mode != m && i < limit) begin
         tick(1);
         i++;
      end
      check("mode_reach", int'(mode), int'(m));
   endtask

   // Scoreboard: every opnd_valid pulse must match the oldest expected operand.
   always @(negedge clk) begin
      logic [3:0] e;
      if (rst_n && opnd_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_valid: op=%b with nothing expected at %0t", op_now, $time);
         end else begin
            e = exp_q.pop_front();
            check("sb_op", int'(op_now), int'(e));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal;
   end

   initial begin
      vecs[0] = '{sw: 4'b1000, exp_op: 4'b1000, exp_valid: 1'b0};
      vecs[1] = '{sw: 4'b0110, exp_op: 4'b0110, exp_valid: 1'b1};
      vecs[2] = '{sw: 4'b1111, exp_op: 4'b1111, exp_valid: 1'b1};
      vecs[3] = '{sw: 4'b1111, exp_op: 4'b1111, exp_valid: 1'b0};
      vecs[4] = '{sw: 4'b0101, exp_op: 4'b0101, exp_valid: 1'b1};
      vecs[5] = '{sw: 4'b0000, exp_op: 4'b0000, exp_valid: 1'b1};

      tick(3);
      check("rst_op", int'(op_now), 0);
      check("rst_mode", int'(mode), 0);
      check("rst_valid", int'(opnd_valid), 0);
      rst_n = 1'b1;
      tick(2);

      // clean switch edge: op after 7 edges, valid one cycle later
      sw_a1 = 1'b1;
      exp_q.push_back(4'b1000);
      tick(6);
      check("t1_op_early", int'(op_now), 0);
      tick(1);
      check("t1_op", int'(op_now), 8);
      check("t1_valid_lag", int'(opnd_valid), 0);
      tick(1);
      check("t1_valid", int'(opnd_valid), 1);
      check("t1_mode", int'(mode), 0);
      tick(1);
      check("t1_valid_end", int'(opnd_valid), 0);

      for (int i = 0; i < 6; i++) begin
         set_sw(vecs[i].sw);
         if (vecs[i].exp_valid) exp_q.push_back(vecs[i].exp_op);
         tick(7);
         check("vec_op", int'(op_now), int'(vecs[i].exp_op));
         tick(1);
         check("vec_valid", int'(opnd_valid), int'(vecs[i].exp_valid));
         tick(2);
      end

      // step press in MANUAL is ignored
      btn_step = 1'b1;
      tick(8);
      btn_step = 1'b0;
      tick(8);
      check("manual_step_op", int'(op_now), 0);
      check("manual_step_mode", int'(mode), 0);

      // bounce shorter than the debounce window never reaches op
      for (int i = 0; i < 10; i++) begin
         sw_b0 = ~sw_b0;
         tick(2);
         check("bounce_op", int'(op_now), 0);
      end
      sw_b0 = 1'b1;
      exp_q.push_back(4'b0001);
      tick(6);
      check("bounce_early", int'(op_now), 0);
      tick(1);
      check("bounce_final", int'(op_now), 1);
      tick(3);

      sw_b0 = 1'b0;
      exp_q.push_back(4'b0000);
      tick(10);
      check("pre_auto_op", int'(op_now), 0);

      // AUTO: held button gives one mode step, op advances every DW cycles
      btn_mode = 1'b1;
      fork
         begin
            repeat (10) @(negedge clk);
            btn_mode = 1'b0;
         end
      join_none
      wait_mode(2'b01, 12);
      for (int k = 1; k <= 16; k++) begin
         logic [3:0] e;
         logic [3:0] p;
         e = 4'(k);
         p = 4'(k - 1);
         exp_q.push_back(e);
         tick(DW - 1);
         check("auto_hold", int'(op_now), int'(p));
         check("auto_mode", int'(mode), 1);
         tick(1);
         check("auto_step", int'(op_now), int'(e));
      end

      // STEP: 16 presses walk op through the wrap 1111 -> 0000
      btn_mode = 1'b1;
      wait_mode(2'b10, 12);
      btn_mode = 1'b0;
      check("step_entry_op", int'(op_now), 0);
      tick(10);
      for (int k = 1; k <= 16; k++) begin
         logic [3:0] e;
         e = 4'(k);
         exp_q.push_back(e);
         btn_step = 1'b1;
         tick(8);
         btn_step = 1'b0;
         tick(8);
         check("step_op", int'(op_now), int'(e));
      end
      check("step_mode", int'(mode), 2);

      // simultaneous mode and step press: mode wins, step discarded
      btn_mode = 1'b1;
      btn_step = 1'b1;
      tick(10);
      check("simul_mode", int'(mode), 0);
      check("simul_op", int'(op_now), 0);
      btn_mode = 1'b0;
      btn_step = 1'b0;
      tick(10);
      check("simul_mode_hold", int'(mode), 0);

      // asynchronous reset in the middle of an AUTO dwell
      set_sw(4'b0101);
      exp_q.push_back(4'b0101);
      tick(10);
      check("pre_rst_op", int'(op_now), 5);
      btn_mode = 1'b1;
      wait_mode(2'b01, 12);
      btn_mode = 1'b0;
      tick(2);
      check("auto_mid_op", int'(op_now), 5);
      rst_n = 1'b0;
      #1;
      check("async_rst_op", int'(op_now), 0);
      check("async_rst_mode", int'(mode), 0);
      check("async_rst_valid", int'(opnd_valid), 0);
      tick(2);
      rst_n = 1'b1;
      exp_q.push_back(4'b0101);
      tick(6);
      check("post_rst_early", int'(op_now), 0);
      tick(1);
      check("post_rst_op", int'(op_now), 5);
      tick(3);
      check("post_rst_mode", int'(mode), 0);

      check("sb_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
